// File: rtl/filterbank_pkg.sv
// Shared constants and types for the profir filter bank and its band mixer.
package filterbank_pkg;

    localparam int NBANDS = 8;
    localparam int DW     = 16;
    localparam int GW     = 18;
    localparam int GFRAC  = 16;
    localparam int AW     = 38;
    localparam int PW     = DW + GW;

    localparam logic signed [GW-1:0] GAIN_UNITY = 18'h10000;
    localparam logic signed [DW-1:0] SAT_MAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [AW-1:0] ROUND_HALF = {{(AW-GFRAC){1'b0}}, 1'b1, {(GFRAC-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

endpackage

// File: rtl/band_gain_regfile.sv
// Shadow/active band gain banks; a commit request moves shadow into active at the next frame start.
module band_gain_regfile
    import filterbank_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 gain_we,
    input  logic [2:0]           gain_addr,
    input  logic signed [GW-1:0] gain_data,
    input  logic                 gain_commit,
    input  logic                 frame_start,
    input  logic [2:0]           rd_idx,
    output logic signed [GW-1:0] rd_gain,
    output logic                 commit_pending
);

    logic signed [GW-1:0] r_shadow [NBANDS];
    logic signed [GW-1:0] r_active [NBANDS];
    logic                 r_pending;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NBANDS; i++) begin
                r_shadow[i] <= GAIN_UNITY;
                r_active[i] <= GAIN_UNITY;
            end
            r_pending <= 1'b0;
        end else begin
            if (gain_we)
                r_shadow[gain_addr] <= gain_data;
            // Transfer sees shadow before this edge's write; a commit on the start edge waits a frame.
            if (frame_start) begin
                if (r_pending) begin
                    for (int unsigned i = 0; i < NBANDS; i++)
                        r_active[i] <= r_shadow[i];
                end
                r_pending <= gain_commit;
            end else if (gain_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign rd_gain        = r_active[rd_idx];
    assign commit_pending = r_pending;

endmodule

// File: rtl/band_mixer.sv
// Weights the 8 filter-bank bands by programmable gains with one shared MAC, then rounds and saturates.
module band_mixer
    import filterbank_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 din_enable,
    input  logic signed [DW-1:0] band0,
    input  logic signed [DW-1:0] band1,
    input  logic signed [DW-1:0] band2,
    input  logic signed [DW-1:0] band3,
    input  logic signed [DW-1:0] band4,
    input  logic signed [DW-1:0] band5,
    input  logic signed [DW-1:0] band6,
    input  logic signed [DW-1:0] band7,
    input  logic                 gain_we,
    input  logic [2:0]           gain_addr,
    input  logic signed [GW-1:0] gain_data,
    input  logic                 gain_commit,
    output logic signed [DW-1:0] mixout,
    output logic                 mixout_valid,
    output logic                 busy,
    output logic                 overrun
);

    state_t               r_state;
    logic [2:0]           r_idx;
    logic signed [DW-1:0] r_cap [NBANDS];
    logic signed [AW-1:0] r_acc;
    logic signed [DW-1:0] r_mixout;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_overrun;

    logic                 w_start;
    logic signed [GW-1:0] w_gain;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_prod_ext;
    logic signed [AW-1:0] w_rnd;
    logic signed [AW-1:0] w_shift;
    logic                 w_fits;
    logic signed [DW-1:0] w_sat;
    logic                 w_pending;

    assign w_start = (r_state == IDLE) && din_enable;

    band_gain_regfile u_gains (
        .clock          (clock),
        .reset          (reset),
        .gain_we        (gain_we),
        .gain_addr      (gain_addr),
        .gain_data      (gain_data),
        .gain_commit    (gain_commit),
        .frame_start    (w_start),
        .rd_idx         (r_idx),
        .rd_gain        (w_gain),
        .commit_pending (w_pending)
    );

    always_comb begin
        w_prod     = r_cap[r_idx] * w_gain;
        w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
        w_rnd      = r_acc + ROUND_HALF;
        w_shift    = w_rnd >>> GFRAC;
        // In range only when every bit above the output sign bit matches it.
        w_fits     = (w_shift[AW-1:DW-1] == '0) || (w_shift[AW-1:DW-1] == '1);
        w_sat      = w_fits ? w_shift[DW-1:0] : (w_shift[AW-1] ? SAT_MIN : SAT_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_mixout  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            for (int unsigned i = 0; i < NBANDS; i++)
                r_cap[i] <= '0;
        end else begin
            r_valid <= 1'b0;
            if (din_enable && r_state != IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (din_enable) begin
                        r_cap[0] <= band0;
                        r_cap[1] <= band1;
                        r_cap[2] <= band2;
                        r_cap[3] <= band3;
                        r_cap[4] <= band4;
                        r_cap[5] <= band5;
                        r_cap[6] <= band6;
                        r_cap[7] <= band7;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'd7)
                        r_state <= OUT;
                end
                OUT: begin
                    r_mixout <= w_sat;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mixout       = r_mixout;
    assign mixout_valid = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_band_mixer.sv
// Directed self-checking bench for band_mixer with hand-computed expected mix results.
module tb_band_mixer;

    logic               clock = 1'b0;
    logic               reset;
    logic               din_enable;
    logic signed [15:0] band0, band1, band2, band3, band4, band5, band6, band7;
    logic               gain_we;
    logic [2:0]         gain_addr;
    logic signed [17:0] gain_data;
    logic               gain_commit;
    logic signed [15:0] mixout;
    logic               mixout_valid;
    logic               busy;
    logic               overrun;

    int checks   = 0;
    int failures = 0;

    band_mixer dut (
        .clock        (clock),
        .reset        (reset),
        .din_enable   (din_enable),
        .band0        (band0),
        .band1        (band1),
        .band2        (band2),
        .band3        (band3),
        .band4        (band4),
        .band5        (band5),
        .band6        (band6),
        .band7        (band7),
        .gain_we      (gain_we),
        .gain_addr    (gain_addr),
        .gain_data    (gain_data),
        .gain_commit  (gain_commit),
        .mixout       (mixout),
        .mixout_valid (mixout_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_bands(input int v);
        band0 = 16'(v); band1 = 16'(v); band2 = 16'(v); band3 = 16'(v);
        band4 = 16'(v); band5 = 16'(v); band6 = 16'(v); band7 = 16'(v);
    endtask

    task automatic write_gain(input int addr, input logic [17:0] data, input bit commit);
        gain_we     = 1'b1;
        gain_addr   = 3'(addr);
        gain_data   = data;
        gain_commit = commit;
        @(posedge clock); #1;
        gain_we     = 1'b0;
        gain_commit = 1'b0;
    endtask

    task automatic commit_pulse();
        gain_commit = 1'b1;
        @(posedge clock); #1;
        gain_commit = 1'b0;
    endtask

    // Starts a frame, checks 9-clock latency, result and single-cycle valid.
    task automatic run_frame(input string tag, input int exp, input bit commit);
        int lat;
        din_enable  = 1'b1;
        gain_commit = commit;
        @(posedge clock); #1;
        din_enable  = 1'b0;
        gain_commit = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock); #1;
            if (mixout_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_mixout"}, int'(mixout), exp);
        check({tag, "_busy_done"}, int'(busy), 0);
        @(posedge clock); #1;
        check({tag, "_valid_1cyc"}, int'(mixout_valid), 0);
    endtask

    initial begin
        int pulses;
        int first;

        reset = 1'b1; din_enable = 1'b0; gain_we = 1'b0; gain_addr = '0;
        gain_data = '0; gain_commit = 1'b0;
        set_bands(0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        check("rst_mixout",  int'(mixout), 0);
        check("rst_valid",   int'(mixout_valid), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);

        // 1: unity gains
        run_frame("first_zero", 0, 1'b0);
        set_bands(1000);
        run_frame("unity", 8000, 1'b0);

        // 2: gain3 = 0.5, others 0
        for (int i = 0; i < 8; i++)
            write_gain(i, (i == 3) ? 18'h08000 : 18'h00000, 1'b0);
        run_frame("shadow_only", 8000, 1'b0);
        commit_pulse();
        run_frame("half3", 500, 1'b0);
        band3 = -16'sd2000;
        run_frame("half3_neg", -1000, 1'b0);
        write_gain(3, 18'h10000, 1'b0);
        run_frame("commit_coinc", -1000, 1'b1);
        run_frame("commit_deferred", -2000, 1'b0);

        // 3: saturation, commit coincident with last write
        for (int i = 0; i < 8; i++)
            write_gain(i, 18'h1FFFF, i == 7);
        set_bands(32767);
        run_frame("sat_pos", 32767, 1'b0);
        set_bands(-32768);
        run_frame("sat_neg", -32768, 1'b0);

        // 4: rounding with gain0 = 0.5
        for (int i = 0; i < 8; i++)
            write_gain(i, (i == 0) ? 18'h08000 : 18'h00000, i == 7);
        set_bands(7777);
        band0 = 16'sd3;  run_frame("rnd_p3", 2, 1'b0);
        band0 = -16'sd3; run_frame("rnd_m3", -1, 1'b0);
        band0 = 16'sd1;  run_frame("rnd_p1", 1, 1'b0);
        band0 = -16'sd1; run_frame("rnd_m1", 0, 1'b0);

        // 5: din_enable while busy
        check("pre_overrun", int'(overrun), 0);
        band0 = 16'sd1000;
        din_enable = 1'b1;
        @(posedge clock); #1;
        din_enable = 1'b0;
        repeat (3) @(posedge clock);
        #1 din_enable = 1'b1;
        @(posedge clock); #1;
        din_enable = 1'b0;
        check("overrun_set", int'(overrun), 1);
        pulses = 0;
        first  = 0;
        for (int n = 5; n <= 25; n++) begin
            @(posedge clock); #1;
            if (mixout_valid) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_latency", first, 9);
        check("ovr_mixout", int'(mixout), 500);
        check("overrun_sticky", int'(overrun), 1);

        // 6: async reset mid-frame (MAC idx 4)
        set_bands(1000);
        din_enable = 1'b1;
        @(posedge clock); #1;
        din_enable = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("arst_mixout",  int'(mixout), 0);
        check("arst_busy",    int'(busy), 0);
        check("arst_valid",   int'(mixout_valid), 0);
        check("arst_overrun", int'(overrun), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clock); #1;
            if (mixout_valid) pulses++;
        end
        check("arst_no_valid", pulses, 0);
        run_frame("post_reset", 8000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
